// File: rtl/cmp_binary_searcher.sv
// Binary-search initiator: drives the comparator B operand and narrows [lo, hi] to find the switch value A.
// Optional two-cycle probe (PROBE then SETTLE) is compiled in with `define CMP_SEARCH_SETTLE_EN.
module cmp_binary_searcher #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_cmp_res,
    output logic [WIDTH-1:0]  o_guess,
    output logic              o_probe,
    output logic              o_done,
    output logic              o_hit,
    output logic [WIDTH-1:0]  o_result,
    output logic [STEP_W-1:0] o_steps,
    output logic              o_err
);

    localparam int unsigned      SUM_W   = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MID_VAL = MAX_VAL >> 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_guess;
    logic [WIDTH-1:0]  r_result;
    logic [STEP_W-1:0] r_steps;
    logic              r_probe;
    logic              r_done;
    logic              r_hit;
    logic              r_err;

    logic [WIDTH-1:0]  w_lo_nxt;
    logic [WIDTH-1:0]  w_hi_nxt;
    logic [WIDTH-1:0]  w_guess_nxt;
    logic [WIDTH-1:0]  w_result_nxt;
    logic [STEP_W-1:0] w_steps_nxt;
    logic              w_probe_nxt;
    logic              w_done_nxt;
    logic              w_hit_nxt;
    logic              w_err_nxt;

    logic              w_sample;
    logic              w_launch;
    logic              w_gt;
    logic              w_eq;
    logic              w_lt;
    logic              w_gt_end;
    logic              w_lt_end;
    logic              w_continue;
    logic [WIDTH-1:0]  w_lo_up;
    logic [WIDTH-1:0]  w_hi_dn;
    logic [SUM_W-1:0]  w_sum_up;
    logic [SUM_W-1:0]  w_sum_dn;

    // Which state samples the comparator result.
`ifdef CMP_SEARCH_SETTLE_EN
    assign w_sample = (r_state == S_SETTLE);
`else
    assign w_sample = (r_state == S_PROBE);
`endif

    assign w_launch = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

    assign w_gt = (i_cmp_res == 3'b100);
    assign w_eq = (i_cmp_res == 3'b010);
    assign w_lt = (i_cmp_res == 3'b001);

    // Midpoint sums carry an extra bit; the end checks stop lo/hi from wrapping or crossing.
    assign w_lo_up  = r_guess + WIDTH'(1);
    assign w_hi_dn  = r_guess - WIDTH'(1);
    assign w_sum_up = SUM_W'(w_lo_up) + SUM_W'(r_hi);
    assign w_sum_dn = SUM_W'(r_lo) + SUM_W'(w_hi_dn);
    assign w_gt_end = (r_guess == MAX_VAL) || (w_lo_up > r_hi);
    assign w_lt_end = (r_guess == '0) || (r_lo > w_hi_dn);

    assign w_continue = (w_gt && !w_gt_end) || (w_lt && !w_lt_end);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_PROBE;
            S_DONE:   if (i_start) w_state_nxt = S_PROBE;
`ifdef CMP_SEARCH_SETTLE_EN
            S_PROBE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = w_continue ? S_PROBE : S_DONE;
`else
            S_PROBE:  w_state_nxt = w_continue ? S_PROBE : S_DONE;
            S_SETTLE: w_state_nxt = S_IDLE;
`endif
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and search bounds.
    always_comb begin
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_steps_nxt  = r_steps;
        w_hit_nxt    = r_hit;
        w_err_nxt    = r_err;
        w_done_nxt   = (w_state_nxt == S_DONE);
`ifdef CMP_SEARCH_SETTLE_EN
        w_probe_nxt  = (w_state_nxt == S_SETTLE);
`else
        w_probe_nxt  = (w_state_nxt == S_PROBE);
`endif

        if (w_launch) begin
            w_lo_nxt    = '0;
            w_hi_nxt    = MAX_VAL;
            w_guess_nxt = MID_VAL;
            w_steps_nxt = STEP_W'(1);
            w_hit_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
        end else if (w_sample) begin
            if (w_eq) begin
                w_result_nxt = r_guess;
                w_hit_nxt    = 1'b1;
            end else if (w_gt) begin
                w_hit_nxt = 1'b0;
                if (!w_gt_end) begin
                    w_lo_nxt    = w_lo_up;
                    w_guess_nxt = WIDTH'(w_sum_up >> 1);
                    w_steps_nxt = r_steps + STEP_W'(1);
                end
            end else if (w_lt) begin
                w_hit_nxt = 1'b0;
                if (!w_lt_end) begin
                    w_hi_nxt    = w_hi_dn;
                    w_guess_nxt = WIDTH'(w_sum_dn >> 1);
                    w_steps_nxt = r_steps + STEP_W'(1);
                end
            end else begin
                w_err_nxt = 1'b1;
                w_hit_nxt = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lo     <= '0;
            r_hi     <= MAX_VAL;
            r_guess  <= '0;
            r_result <= '0;
            r_steps  <= '0;
            r_probe  <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_steps  <= w_steps_nxt;
            r_probe  <= w_probe_nxt;
            r_done   <= w_done_nxt;
            r_hit    <= w_hit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign o_guess  = r_guess;
    assign o_probe  = r_probe;
    assign o_done   = r_done;
    assign o_hit    = r_hit;
    assign o_result = r_result;
    assign o_steps  = r_steps;
    assign o_err    = r_err;

endmodule

// File: tb/tb_cmp_binary_searcher.sv
// Bench for cmp_binary_searcher: behavioural comparator, directed target table, scripted corner cases.
module tb_cmp_binary_searcher;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 3;
`ifdef CMP_SEARCH_SETTLE_EN
    localparam int LAT_F = 2;
`else
    localparam int LAT_F = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        cmp_res;
    logic [WIDTH-1:0]  guess;
    logic              probe;
    logic              done;
    logic              hit;
    logic [WIDTH-1:0]  result;
    logic [STEP_W-1:0] steps;
    logic              err;

    cmp_binary_searcher #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_cmp_res (cmp_res),
        .o_guess   (guess),
        .o_probe   (probe),
        .o_done    (done),
        .o_hit     (hit),
        .o_result  (result),
        .o_steps   (steps),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    // Comparator model, or a per-probe scripted response.
    logic [3:0] target;
    logic       use_script;
    logic [2:0] script_val;
    logic [2:0] script [8];

    always_comb begin
        if (use_script)          cmp_res = script_val;
        else if (target > guess) cmp_res = 3'b100;
        else if (target == guess) cmp_res = 3'b010;
        else                     cmp_res = 3'b001;
    end

    int checks   = 0;
    int failures = 0;
    int lat;
    int g_cnt;
    int g_hist [8];

    typedef struct {
        logic [3:0] target;
        int         steps;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start a search from IDLE/DONE and follow it to done, logging each probed guess.
    task automatic run_search(input logic [3:0] t, input bit toggle);
        target = t;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        g_cnt = 0;
        while (!done && lat < 40) begin
            if (probe && g_cnt < 8) begin
                g_hist[g_cnt] = guess;
                script_val    = script[g_cnt];
                g_cnt++;
            end
            if (toggle) start = ~start;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_reached", done, 1);
    endtask

    task automatic chk_guesses(input string nm, input int exp [8], input int n);
        chk({nm, "_nprobes"}, g_cnt, n);
        for (int i = 0; i < n && i < g_cnt; i++)
            chk({nm, "_guess"}, g_hist[i], exp[i]);
    endtask

    task automatic chk_outcome(input string nm, input int e_hit, input int e_steps, input int e_err);
        chk({nm, "_done"},  done, 1);
        chk({nm, "_hit"},   hit, e_hit);
        chk({nm, "_steps"}, steps, e_steps);
        chk({nm, "_err"},   err, e_err);
        chk({nm, "_lat"},   lat, e_steps * LAT_F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{'{4'd0, 4}, '{4'd1, 3}, '{4'd2, 4}, '{4'd3, 2},
                 '{4'd4, 4}, '{4'd5, 3}, '{4'd6, 4}, '{4'd7, 1},
                 '{4'd8, 4}, '{4'd9, 3}, '{4'd10, 4}, '{4'd11, 2},
                 '{4'd12, 4}, '{4'd13, 3}, '{4'd14, 4}, '{4'd15, 5}};
        for (int i = 0; i < 8; i++) script[i] = 3'b010;
        rst        = 1'b1;
        start      = 1'b0;
        target     = 4'd0;
        use_script = 1'b0;
        script_val = 3'b010;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_guess", guess, 0);
        chk("rst_probe", probe, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_result", result, 0);
        chk("rst_steps", steps, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", done, 0);
        chk("idle_probe", probe, 0);

        // Single-probe hit.
        run_search(4'd7, 1'b0);
        chk_outcome("t7", 1, 1, 0);
        chk("t7_result", result, 7);
        chk_guesses("t7", '{7, 0, 0, 0, 0, 0, 0, 0}, 1);

        // Top of range: worst-case probe count.
        run_search(4'd15, 1'b0);
        chk_outcome("t15", 1, 5, 0);
        chk("t15_result", result, 15);
        chk_guesses("t15", '{7, 11, 13, 14, 15, 0, 0, 0}, 5);

        // Bottom of range.
        run_search(4'd0, 1'b0);
        chk_outcome("t0", 1, 4, 0);
        chk("t0_result", result, 0);
        chk_guesses("t0", '{7, 3, 1, 0, 0, 0, 0, 0}, 4);

        // Start toggling during the search is ignored.
        run_search(4'd13, 1'b1);
        chk_outcome("t13tog", 1, 3, 0);
        chk("t13tog_result", result, 13);
        chk_guesses("t13tog", '{7, 11, 13, 0, 0, 0, 0, 0}, 3);

        // Full target table.
        for (int i = 0; i < 16; i++) begin
            run_search(vecs[i].target, 1'b0);
            chk_outcome("tbl", 1, vecs[i].steps, 0);
            chk("tbl_result", result, int'(vecs[i].target));
        end

        // Non-one-hot result on first probe, then a clean search.
        use_script = 1'b1;
        script[0]  = 3'b000;
        run_search(4'd5, 1'b0);
        chk_outcome("err", 0, 1, 1);
        use_script = 1'b0;
        run_search(4'd5, 1'b0);
        chk_outcome("after_err", 1, 3, 0);
        chk("after_err_result", result, 5);

        // Always "greater": range exhausted at max without wrapping.
        use_script = 1'b1;
        for (int i = 0; i < 8; i++) script[i] = 3'b100;
        run_search(4'd0, 1'b0);
        chk_outcome("all_gt", 0, 5, 0);
        chk_guesses("all_gt", '{7, 11, 13, 14, 15, 0, 0, 0}, 5);
        chk("all_gt_hold", guess, 15);

        // Always "less": range exhausted at zero without wrapping.
        for (int i = 0; i < 8; i++) script[i] = 3'b001;
        run_search(4'd0, 1'b0);
        chk_outcome("all_lt", 0, 4, 0);
        chk_guesses("all_lt", '{7, 3, 1, 0, 0, 0, 0, 0}, 4);
        chk("all_lt_hold", guess, 0);

        // Inconsistent answers cross lo over hi.
        script[0] = 3'b100;
        script[1] = 3'b001;
        script[2] = 3'b100;
        script[3] = 3'b001;
        run_search(4'd0, 1'b0);
        chk_outcome("cross", 0, 4, 0);
        chk_guesses("cross", '{7, 11, 9, 10, 0, 0, 0, 0}, 4);
        chk("cross_hold", guess, 10);
        use_script = 1'b0;

        // Asynchronous reset mid-search, then idle until start.
        target = 4'd10;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_guess", guess, 0);
        chk("mid_rst_probe", probe, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_hit", hit, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_steps", steps, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_done", done, 0);
        chk("post_rst_probe", probe, 0);
        chk("post_rst_steps", steps, 0);
        run_search(4'd10, 1'b0);
        chk_outcome("t10", 1, 4, 0);
        chk("t10_result", result, 10);
        chk_guesses("t10", '{7, 11, 9, 10, 0, 0, 0, 0}, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
